// File: rtl/fifo_pkg.sv
// Shared helpers for the inferred-RAM FIFO: address sizing and read-pipeline modes.
package fifo_pkg;

    localparam int RD_COMB_RAM = 0;
    localparam int RD_REG_OUT  = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one enabled read port, optional output register.
module sdp_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2048,
    parameter int REG_RD = RD_COMB_RAM
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      i_wen,
    input  logic [clog2(DEPTH)-1:0]   i_waddr,
    input  logic [DATA_W-1:0]         i_wdata,
    input  logic                      i_ren,
    input  logic [clog2(DEPTH)-1:0]   i_raddr,
    output logic [DATA_W-1:0]         o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_q;

    always_ff @(posedge Clk) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    generate
        if (REG_RD == RD_REG_OUT) begin : g_out_reg
            logic              r_ren_d;
            logic [DATA_W-1:0] r_rd_out;

            // The array read register stays reset-free so it maps onto the RAM primitive.
            always_ff @(posedge Clk) begin
                if (i_ren) begin
                    r_rd_q <= r_mem[i_raddr];
                end
            end

            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    r_ren_d  <= 1'b0;
                    r_rd_out <= '0;
                end else begin
                    r_ren_d <= i_ren;
                    if (r_ren_d) begin
                        r_rd_out <= r_rd_q;
                    end
                end
            end

            assign o_rdata = r_rd_out;
        end else begin : g_no_reg
            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    r_rd_q <= '0;
                end else if (i_ren) begin
                    r_rd_q <= r_mem[i_raddr];
                end
            end

            assign o_rdata = r_rd_q;
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO over an inferred SDP RAM with occupancy, threshold flags and sticky errors.
module sync_fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2048,
    parameter int REG_RD = RD_COMB_RAM,
    parameter int AF_LVL = DEPTH - 4,
    parameter int AE_LVL = 4
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    WEN,
    input  logic [DATA_W-1:0]       WD,
    input  logic                    REN,
    output logic [DATA_W-1:0]       RD,
    output logic                    RValid,
    output logic                    Full,
    output logic                    Empty,
    output logic                    AlmostFull,
    output logic                    AlmostEmpty,
    output logic [clog2(DEPTH):0]   Count,
    output logic                    Overflow,
    output logic                    Underflow
);

    localparam int ADDR_W = clog2(DEPTH);
    localparam int CNT_W  = cnt_w(DEPTH);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic [REG_RD:0]   r_vld;
    logic [REG_RD:0]   w_vld_next;
    logic              w_push;
    logic              w_pop;

    // Full/Empty gating keeps the RAM from ever reading and writing one address together.
    assign w_push = WEN & ~Full;
    assign w_pop  = REN & ~Empty;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_comb begin
        w_vld_next    = r_vld << 1;
        w_vld_next[0] = w_pop;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_vld       <= '0;
            Full        <= 1'b0;
            Empty       <= 1'b1;
            AlmostFull  <= 1'b0;
            AlmostEmpty <= 1'b1;
            Overflow    <= 1'b0;
            Underflow   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_count     <= w_count_next;
            r_vld       <= w_vld_next;
            Full        <= (w_count_next == CNT_W'(DEPTH));
            Empty       <= (w_count_next == '0);
            AlmostFull  <= (w_count_next >= CNT_W'(AF_LVL));
            AlmostEmpty <= (w_count_next <= CNT_W'(AE_LVL));
            if (WEN && Full) begin
                Overflow <= 1'b1;
            end
            if (REN && Empty) begin
                Underflow <= 1'b1;
            end
        end
    end

    assign Count  = r_count;
    assign RValid = r_vld[REG_RD];

    sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .REG_RD (REG_RD)
    ) u_ram (
        .Clk     (Clk),
        .Rst     (Rst),
        .i_wen   (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (WD),
        .i_ren   (w_pop),
        .i_raddr (r_rd_ptr),
        .o_rdata (RD)
    );

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Drives two FIFOs (combinational-RAM and registered-output reads) with identical traffic
// and checks them against a queue model and a read-data scoreboard.
module tb_sync_fifo_ram;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF_LVL = 12;
    localparam int AE_LVL = 4;

    typedef struct {
        logic [DATA_W-1:0] d;
        int                c;
    } exp_t;

    logic              Clk;
    logic              Rst;
    logic              WEN;
    logic              REN;
    logic [DATA_W-1:0] WD;

    logic [DATA_W-1:0] RD_0, RD_1;
    logic              RValid_0, RValid_1;
    logic              Full_0, Full_1, Empty_0, Empty_1;
    logic              AF_0, AF_1, AE_0, AE_1;
    logic [4:0]        Count_0, Count_1;
    logic              Ovf_0, Ovf_1, Unf_0, Unf_1;

    int                n_tests;
    int                n_fail;
    int                cyc;
    int                mq[$];
    bit                m_ovf;
    bit                m_unf;
    exp_t              sb0[$];
    exp_t              sb1[$];
    int                last_rd[2];

    sync_fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .REG_RD(0), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)) dut0 (
        .Clk(Clk), .Rst(Rst), .WEN(WEN), .WD(WD), .REN(REN), .RD(RD_0), .RValid(RValid_0),
        .Full(Full_0), .Empty(Empty_0), .AlmostFull(AF_0), .AlmostEmpty(AE_0), .Count(Count_0),
        .Overflow(Ovf_0), .Underflow(Unf_0)
    );

    sync_fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .REG_RD(1), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)) dut1 (
        .Clk(Clk), .Rst(Rst), .WEN(WEN), .WD(WD), .REN(REN), .RD(RD_1), .RValid(RValid_1),
        .Full(Full_1), .Empty(Empty_1), .AlmostFull(AF_1), .AlmostEmpty(AE_1), .Count(Count_1),
        .Overflow(Ovf_1), .Underflow(Unf_1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic chk_dut(input string tag, input int k, input int cnt, input bit full, input bit empty,
                           input bit af, input bit ae, input bit ovf, input bit unf);
        int n;
        n = mq.size();
        chk($sformatf("%s/count%0d", tag, k), cnt, n);
        chk($sformatf("%s/full%0d", tag, k), int'(full), int'(n == DEPTH));
        chk($sformatf("%s/empty%0d", tag, k), int'(empty), int'(n == 0));
        chk($sformatf("%s/afull%0d", tag, k), int'(af), int'(n >= AF_LVL));
        chk($sformatf("%s/aempty%0d", tag, k), int'(ae), int'(n <= AE_LVL));
        chk($sformatf("%s/ovf%0d", tag, k), int'(ovf), int'(m_ovf));
        chk($sformatf("%s/unf%0d", tag, k), int'(unf), int'(m_unf));
    endtask

    task automatic check_state(input string tag);
        chk_dut(tag, 0, int'(Count_0), Full_0, Empty_0, AF_0, AE_0, Ovf_0, Unf_0);
        chk_dut(tag, 1, int'(Count_1), Full_1, Empty_1, AF_1, AE_1, Ovf_1, Unf_1);
    endtask

    // One clock of traffic; the model decides acceptance from the occupancy before the edge.
    task automatic step(input string tag, input bit wen, input bit ren, input logic [DATA_W-1:0] wd);
        bit   push;
        bit   pop;
        exp_t e;
        WEN  = wen;
        REN  = ren;
        WD   = wd;
        push = wen && (mq.size() < DEPTH);
        pop  = ren && (mq.size() > 0);
        if (wen && !push) m_ovf = 1'b1;
        if (ren && !pop) m_unf = 1'b1;
        if (pop) begin
            e.d = DATA_W'(mq.pop_front());
            e.c = cyc + 1;
            sb0.push_back(e);
            e.c = cyc + 2;
            sb1.push_back(e);
        end
        if (push) mq.push_back(int'(wd));
        @(posedge Clk);
        #1;
        WEN = 1'b0;
        REN = 1'b0;
        check_state(tag);
    endtask

    // Asserts reset between clock edges and checks that everything clears before the next edge.
    task automatic do_reset(input string tag);
        #2 Rst = 1'b1;
        #1;
        mq.delete();
        sb0.delete();
        sb1.delete();
        m_ovf      = 1'b0;
        m_unf      = 1'b0;
        last_rd[0] = 0;
        last_rd[1] = 0;
        check_state(tag);
        chk({tag, "/rvalid0"}, int'(RValid_0), 0);
        chk({tag, "/rvalid1"}, int'(RValid_1), 0);
        chk({tag, "/rd0"}, int'(RD_0), 0);
        chk({tag, "/rd1"}, int'(RD_1), 0);
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    task automatic mon(input int k, input logic v, input logic [DATA_W-1:0] d);
        exp_t e;
        bit   have;
        have = (k == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
        if (have) e = (k == 0) ? sb0[0] : sb1[0];
        if (v) begin
            if (have && e.c == cyc) begin
                if (k == 0) void'(sb0.pop_front());
                else        void'(sb1.pop_front());
                chk($sformatf("rd_data%0d", k), int'(d), int'(e.d));
            end else begin
                chk($sformatf("rvalid_unexpected%0d", k), 1, 0);
            end
            last_rd[k] = int'(d);
        end else begin
            if (have && e.c <= cyc) begin
                if (k == 0) void'(sb0.pop_front());
                else        void'(sb1.pop_front());
                chk($sformatf("rvalid_missing%0d", k), 0, 1);
            end
            chk($sformatf("rd_hold%0d", k), int'(d), last_rd[k]);
        end
    endtask

    always @(negedge Clk) begin
        mon(0, RValid_0, RD_0);
        mon(1, RValid_1, RD_1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        Rst     = 1'b1;
        WEN     = 1'b0;
        REN     = 1'b0;
        WD      = '0;
        @(posedge Clk);
        #1;
        do_reset("init");

        // Reset mid-operation, with a pop still in flight.
        for (int i = 0; i < 5; i++) step("rst_fill", 1'b1, 1'b0, DATA_W'($urandom));
        step("rst_pop", 1'b0, 1'b1, '0);
        do_reset("rst_mid");
        step("rst_unf", 1'b0, 1'b1, '0);

        // Fill to full, overflow, full with both requests, then drain.
        do_reset("fill_rst");
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, DATA_W'(i));
        step("ovf", 1'b1, 1'b0, 8'hAA);
        step("full_both", 1'b1, 1'b1, 8'hAB);
        for (int i = 0; i < DEPTH + 2; i++) step("drain", 1'b0, 1'b1, '0);

        // Steady-state push and pop at half occupancy, wrapping the pointers.
        for (int i = 0; i < 8; i++) step("half", 1'b1, 1'b0, DATA_W'($urandom));
        for (int i = 0; i < 20; i++) step("both", 1'b1, 1'b1, DATA_W'($urandom));
        for (int i = 0; i < 10; i++) step("drain2", 1'b0, 1'b1, '0);

        // Both requests while empty: push only.
        do_reset("empty_rst");
        step("empty_both", 1'b1, 1'b1, 8'h33);
        step("idle", 1'b0, 1'b0, '0);
        step("pop33", 1'b0, 1'b1, '0);

        // Single word through both read pipelines.
        step("push5c", 1'b1, 1'b0, 8'h5C);
        step("pop5c", 1'b0, 1'b1, '0);
        step("idle", 1'b0, 1'b0, '0);
        step("idle", 1'b0, 1'b0, '0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step("rnd", ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50), DATA_W'($urandom));
            end
        end
        for (int i = 0; i < DEPTH + 4; i++) step("final_drain", 1'b0, 1'b1, '0);

        chk("sb0_left", sb0.size(), 0);
        chk("sb1_left", sb1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
